// File: rtl/round_referee.sv
// Two-player reaction referee: random arm delay, GO window, one-cycle victory pulses, match end.
// Build option ROUND_REFEREE_FOUL_EN: a press while armed is a foul and awards the opponent.
module round_referee #(
   parameter int unsigned DELAY_MIN  = 50_000_000,
   parameter logic [15:0] DELAY_MASK = 16'h7FFF,
   parameter int unsigned TIMEOUT    = 100_000_000,
   parameter int unsigned HOLDOFF    = 25_000_000,
   parameter int unsigned MAX_POINTS = 7
) (
   input  logic clock,
   input  logic reset,
   input  logic btn1,
   input  logic btn2,
   input  logic start,
   output logic go_led,
   output logic p1vic,
   output logic p2vic,
   output logic busy,
   output logic match_over
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_GO, S_AWARD1, S_AWARD2, S_AWARDT, S_HOLD, S_DONE
   } state_t;

   localparam logic [31:0] DLY_W  = 32'(DELAY_MIN);
   localparam logic [31:0] TMO_W  = 32'(TIMEOUT);
   localparam logic [31:0] HOLD_W = 32'(HOLDOFF);
   localparam logic [2:0]  MAX_P  = 3'(MAX_POINTS);

   state_t      state_q, state_d;
   logic [31:0] tmr_q, tmr_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [2:0]  p1_pts_q, p1_pts_d, p2_pts_q, p2_pts_d;
   logic [1:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [1:0]  press;

   // Index 0 = player 1, index 1 = player 2.
   assign sync1_d = {btn2, btn1};
   assign sync2_d = sync1_q;
   assign prev_d  = sync2_q;
   assign press   = sync2_q & ~prev_q;

   assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      p1_pts_d   = p1_pts_q;
      p2_pts_d   = p2_pts_q;
      go_led     = 1'b0;
      p1vic      = 1'b0;
      p2vic      = 1'b0;
      busy       = 1'b1;
      match_over = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = S_ARMED;
               tmr_d   = DLY_W + {16'd0, lfsr_q & DELAY_MASK};
            end
         end
         S_ARMED: begin
            // Timers hold the remaining cycle count; leave the state on the last one.
            if (tmr_q <= 32'd1) begin
               state_d = S_GO;
               tmr_d   = TMO_W;
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
`ifdef ROUND_REFEREE_FOUL_EN
            if (press[0] && press[1]) begin
               state_d = S_HOLD;
               tmr_d   = HOLD_W;
            end else if (press[0]) begin
               state_d = S_AWARD2;
            end else if (press[1]) begin
               state_d = S_AWARD1;
            end
`endif
         end
         S_GO: begin
            go_led = 1'b1;
            if (press[0] && press[1]) begin
               state_d = S_AWARDT;
            end else if (press[0]) begin
               state_d = S_AWARD1;
            end else if (press[1]) begin
               state_d = S_AWARD2;
            end else if (tmr_q <= 32'd1) begin
               state_d = S_HOLD;
               tmr_d   = HOLD_W;
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         S_AWARD1, S_AWARD2, S_AWARDT: begin
            p1vic   = (state_q != S_AWARD2);
            p2vic   = (state_q != S_AWARD1);
            if (p1vic && p1_pts_q != MAX_P) p1_pts_d = p1_pts_q + 3'd1;
            if (p2vic && p2_pts_q != MAX_P) p2_pts_d = p2_pts_q + 3'd1;
            state_d = S_HOLD;
            tmr_d   = HOLD_W;
         end
         S_HOLD: begin
            if (tmr_q <= 32'd1) begin
               state_d = (p1_pts_q == MAX_P || p2_pts_q == MAX_P) ? S_DONE : S_IDLE;
               tmr_d   = 32'd0;
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         S_DONE: begin
            busy       = 1'b0;
            match_over = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         tmr_q    <= 32'd0;
         lfsr_q   <= 16'hACE1;
         p1_pts_q <= 3'd0;
         p2_pts_q <= 3'd0;
         sync1_q  <= 2'b00;
         sync2_q  <= 2'b00;
         prev_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         lfsr_q   <= lfsr_d;
         p1_pts_q <= p1_pts_d;
         p2_pts_q <= p2_pts_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
      end
   end

endmodule
